debug_reg_dumper: RTL

- Reads the whole register bank through the instruction decoder's debug read port and streams it out as bytes to the debug UART transmitter.
- On a start pulse it takes over the sr2 read address and walks registers 0..N_REGISTERS-1.
- It captures each word from the debug data bus and emits it MSB byte first over a valid/ready handshake.
- It runs only while the pipeline is halted. Sequencing the halt is the debug controller's job, not this block's.

---
 rtl/debug_reg_dumper_if.sv | 61 ++++++
 rtl/debug_reg_dumper.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_reg_dumper_if.sv
// -----------------------------------------------------------------------------
// debug_reg_dumper_if
//
// Purpose:
//   Bundles the dump control, the register-bank debug read port and the
//   byte-transmit handshake used by debug_reg_dumper.
//
// Signals:
//   i_start          - one-cycle dump request
//   o_busy           - dumper is not idle
//   o_done           - one-cycle pulse at the end of a dump
//   o_debug          - selects the debug address onto the decoder sr2 port
//   o_debug_reg_addr - register address driven to the decoder
//   i_debug_reg_data - combinational read data from the decoder
//   o_tx_data        - byte to the UART transmitter
//   o_tx_valid       - o_tx_data is valid
//   i_tx_ready       - transmitter accepts the byte this cycle
//
// Modports:
//   master - the dumper itself
//   slave  - the surrounding debug controller / decoder / transmitter
// -----------------------------------------------------------------------------
interface debug_reg_dumper_if #(
    parameter int NB_DATA           = 32,
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int NB_BYTE           = 8
);
    logic                         i_start;
    logic                         o_busy;
    logic                         o_done;
    logic                         o_debug;
    logic [NB_ADDR_REGISTERS-1:0] o_debug_reg_addr;
    logic [NB_DATA-1:0]           i_debug_reg_data;
    logic [NB_BYTE-1:0]           o_tx_data;
    logic                         o_tx_valid;
    logic                         i_tx_ready;

    modport master (
        input  i_start,
        input  i_debug_reg_data,
        input  i_tx_ready,
        output o_busy,
        output o_done,
        output o_debug,
        output o_debug_reg_addr,
        output o_tx_data,
        output o_tx_valid
    );

    modport slave (
        output i_start,
        output i_debug_reg_data,
        output i_tx_ready,
        input  o_busy,
        input  o_done,
        input  o_debug,
        input  o_debug_reg_addr,
        input  o_tx_data,
        input  o_tx_valid
    );
endinterface

// File: rtl/debug_reg_dumper.sv
// -----------------------------------------------------------------------------
// debug_reg_dumper
//
// Purpose:
//   Walks the register bank through the decoder debug read port and streams
//   every register out, MSB byte first, over a valid/ready byte handshake to
//   the debug UART transmitter. Intended to run only while the pipeline is
//   halted; the halt itself is sequenced elsewhere.
//
// Ports:
//   i_clk   - clock, rising-edge active
//   i_reset - asynchronous active-high reset; aborts any dump in progress
//   bus     - debug_reg_dumper_if.master (start/busy/done, debug read port,
//             transmit handshake)
//
// Configuration:
//   DEBUG_DUMP_CHECKSUM_EN - when defined, an XOR checksum byte over every
//   transmitted register byte is appended after the last register (CSUM
//   state). When undefined the dump ends directly after the last register.
// -----------------------------------------------------------------------------
module debug_reg_dumper #(
    parameter int NB_DATA           = 32,
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int N_REGISTERS       = 32,
    parameter int NB_BYTE           = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    debug_reg_dumper_if.master   bus
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [NB_IDX-1:0]            LAST_BYTE = NB_IDX'(N_BYTES - 1);
    localparam logic [NB_ADDR_REGISTERS-1:0] LAST_REG  = NB_ADDR_REGISTERS'(N_REGISTERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SEND   = 3'd2,
`ifdef DEBUG_DUMP_CHECKSUM_EN
        ST_CSUM   = 3'd3,
`endif
        ST_DONE   = 3'd4
    } state_t;

    state_t                       state;
    state_t                       state_next;

    logic [NB_ADDR_REGISTERS-1:0] addr;
    logic [NB_IDX-1:0]            byte_idx;
    logic [NB_DATA-1:0]           word;

    logic                         tx_valid;
    logic [NB_BYTE-1:0]           tx_data;
    logic                         handshake;
    logic                         last_byte;
    logic                         last_reg;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]           csum;
`endif

    // Byte idx of the captured word, counted from the MSB end.
    function automatic logic [NB_BYTE-1:0] byte_at(input logic [NB_DATA-1:0] w,
                                                   input logic [NB_IDX-1:0]  idx);
        logic [NB_DATA-1:0] shifted;
        shifted = w << (int'(idx) * NB_BYTE);
        return shifted[NB_DATA-1 -: NB_BYTE];
    endfunction

    assign handshake = tx_valid & bus.i_tx_ready;
    assign last_byte = (byte_idx == LAST_BYTE);
    assign last_reg  = (addr == LAST_REG);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_next = ST_SELECT;
                end
            end
            // One cycle for the debug address to reach the bank read mux.
            ST_SELECT: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (handshake && last_byte) begin
                    if (last_reg) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        state_next = ST_SELECT;
                    end
                end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (handshake) begin
                    state_next = ST_DONE;
                end
            end
`endif
            // i_start here is deliberately not looked at; a new dump has to
            // be requested from IDLE.
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs (decoded from the registered state, so reset clears them
    // immediately without waiting for a clock edge)
    // ---------------------------------------------------------------------
    always_comb begin
        tx_valid             = 1'b0;
        tx_data              = '0;
        bus.o_busy           = (state != ST_IDLE);
        bus.o_debug          = (state != ST_IDLE);
        bus.o_done           = (state == ST_DONE);
        bus.o_debug_reg_addr = '0;
        if (state != ST_IDLE) begin
            bus.o_debug_reg_addr = addr;
        end
        case (state)
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = byte_at(word, byte_idx);
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
            end
`endif
            default: begin
                tx_valid = 1'b0;
                tx_data  = '0;
            end
        endcase
    end

    assign bus.o_tx_valid = tx_valid;
    assign bus.o_tx_data  = tx_data;

    // ---------------------------------------------------------------------
    // Walk counters: register address and byte index within the word
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr     <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        addr <= '0;
                    end
                end
                ST_SELECT: begin
                    byte_idx <= '0;
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 1'b1;
                        end else if (!last_reg) begin
                            // The last-register compare ends the dump, so
                            // addr never wraps.
                            addr <= addr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Word capture: sampled once in SELECT so later bank writes cannot
    // change a word that is already being transmitted.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (state == ST_SELECT) begin
            word <= bus.i_debug_reg_data;
        end
    end

`ifdef DEBUG_DUMP_CHECKSUM_EN
    // ---------------------------------------------------------------------
    // Running XOR of every register byte accepted by the transmitter
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            csum <= '0;
        end else if (state == ST_IDLE && bus.i_start) begin
            csum <= '0;
        end else if (state == ST_SEND && handshake) begin
            csum <= csum ^ tx_data;
        end
    end
`endif

endmodule
